// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag register and condition-field evaluation gating the write strobes
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic       n, z, c, v;
    logic       cond_ex;
    logic       nz_write;
    logic       cv_write;

    assign {n, z, c, v} = flags_q;

    // Evaluated against the stored flags only, so an instruction never sees its own ALU result.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = n ~^ v;
            4'b1011: cond_ex = n ^ v;
            4'b1100: cond_ex = ~z & (n ~^ v);
            4'b1101: cond_ex = z | (n ^ v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign nz_write = en & cond_ex & FlagW[1];
    assign cv_write = en & cond_ex & FlagW[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (nz_write) flags_q[3:2] <= ALUFlags[3:2];
            if (cv_write) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Strobes ignore en: stalls on the write paths belong to the controller.
    assign PCSrc    = ~reset & PCS  & cond_ex;
    assign RegWrite = ~reset & RegW & cond_ex & ~NoWrite;
    assign MemWrite = ~reset & MemW & cond_ex;
    assign CondEx   = cond_ex;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - directed and randomized bench for cond_logic against a behavioural model
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    int errors = 0;
    int checks = 0;
    int m_flags = 0;

    always #5 clk = ~clk;

    cond_logic dut (
        .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags)
    );

    // Conditions come in complementary pairs; the odd member inverts the even one.
    function automatic bit cond_pass(int cond, int f);
        bit n, z, c, v, p;
        n = ((f >> 3) & 1) != 0;
        z = ((f >> 2) & 1) != 0;
        c = ((f >> 1) & 1) != 0;
        v = (f & 1) != 0;
        case (cond / 2)
            0: p = z;
            1: p = c;
            2: p = n;
            3: p = v;
            4: p = c && !z;
            5: p = (n == v);
            6: p = !z && (n == v);
            default: return cond == 14;
        endcase
        return (cond % 2 == 1) ? !p : p;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [3:0] cd,
                         input logic [3:0] af, input logic [1:0] fw,
                         input logic p, input logic rw, input logic mw, input logic nw);
        bit ok;
        @(negedge clk);
        reset = r; en = e; Cond = cd; ALUFlags = af; FlagW = fw;
        PCS = p; RegW = rw; MemW = mw; NoWrite = nw;
        #1;
        ok = cond_pass(int'(cd), m_flags);
        check("cond_ex", {3'b0, CondEx}, {3'b0, ok});
        check("pc_src",    {3'b0, PCSrc},    {3'b0, !r && p && ok});
        check("reg_write", {3'b0, RegWrite}, {3'b0, !r && rw && ok && !nw});
        check("mem_write", {3'b0, MemWrite}, {3'b0, !r && mw && ok});
        @(posedge clk);
        if (r) m_flags = 0;
        else if (e && ok) begin
            if (fw[1]) m_flags = (m_flags & 3)  | (int'(af) & 12);
            if (fw[0]) m_flags = (m_flags & 12) | (int'(af) & 3);
        end
        #1;
        check("flags", Flags, m_flags[3:0]);
    endtask

    task automatic load_flags(input logic [3:0] f);
        cycle(0, 1, 4'b1110, f, 2'b11, 0, 0, 0, 0);
    endtask

    initial begin
        logic [3:0] sweep [5];
        sweep[0] = 4'b0000; sweep[1] = 4'b1001; sweep[2] = 4'b1000;
        sweep[3] = 4'b0010; sweep[4] = 4'b0110;

        // Reset clear, then the same requests pass once released.
        cycle(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        cycle(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        check("reset_flags", Flags, 4'b0000);
        check("reset_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
        cycle(0, 1, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0);
        check("release_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);

        // CMP then BEQ / BNE.
        cycle(0, 1, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1);
        check("cmp_regwrite", {3'b0, RegWrite}, 4'b0000);
        check("cmp_flags", Flags, 4'b0110);
        cycle(0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
        check("beq_taken", {3'b0, PCSrc}, 4'b0001);
        cycle(0, 1, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0);
        check("bne_not_taken", {3'b0, PCSrc}, 4'b0000);

        // Partial flag write.
        load_flags(4'b1011);
        cycle(0, 1, 4'b1110, 4'b0100, 2'b10, 0, 0, 0, 0);
        check("partial_nz", Flags, 4'b0111);

        // Failed condition is a NOP.
        load_flags(4'b0000);
        cycle(0, 1, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0);
        check("nop_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
        check("nop_flags", Flags, 4'b0000);

        // Condition sweep with spot checks.
        foreach (sweep[i]) begin
            load_flags(sweep[i]);
            for (int cd = 0; cd < 16; cd++) begin
                cycle(0, 1, cd[3:0], 4'b0000, 2'b00, 0, 0, 0, 0);
                if (cd == 15) check("nv_never", {3'b0, CondEx}, 4'b0000);
                if (sweep[i] == 4'b1001 && cd == 10) check("ge_1001", {3'b0, CondEx}, 4'b0001);
                if (sweep[i] == 4'b0110 && cd == 12) check("gt_0110", {3'b0, CondEx}, 4'b0000);
                if (sweep[i] == 4'b0010 && cd == 8)  check("hi_0010", {3'b0, CondEx}, 4'b0001);
                if (sweep[i] == 4'b0110 && cd == 9)  check("ls_0110", {3'b0, CondEx}, 4'b0001);
            end
        end

        // Stall holds, then reset beats a pending write.
        load_flags(4'b0011);
        cycle(0, 0, 4'b1110, 4'b1100, 2'b11, 0, 0, 0, 0);
        check("stall_hold", Flags, 4'b0011);
        cycle(1, 1, 4'b1110, 4'b1100, 2'b11, 0, 0, 0, 0);
        check("reset_priority", Flags, 4'b0000);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
